// File: rtl/fetch_stage_n_if.sv
// Bundle-level connection between the fetch stage, the instruction memory and the IF/ID queue.
// The master modport is the fetch stage; the slave side is the memory/queue environment.
interface fetch_stage_n_if #(
    parameter int FETCH_WIDTH = 2
);
    logic [31:0]               Instr_address_2IM;
    logic                      im_req;
    logic [32*FETCH_WIDTH-1:0] im_rdata;
    logic                      tQ_IFID_full;
    logic                      tQ_IFID_pushReq;
    logic [32*FETCH_WIDTH-1:0] out_instr;
    logic [31:0]               out_pc;
    logic [FETCH_WIDTH-1:0]    out_mask;

    modport master (
        output Instr_address_2IM,
        output im_req,
        input  im_rdata,
        input  tQ_IFID_full,
        output tQ_IFID_pushReq,
        output out_instr,
        output out_pc,
        output out_mask
    );

    modport slave (
        input  Instr_address_2IM,
        input  im_req,
        output im_rdata,
        output tQ_IFID_full,
        input  tQ_IFID_pushReq,
        input  out_instr,
        input  out_pc,
        input  out_mask
    );
endinterface

// File: rtl/fetch_stage_n.sv
// Multi-issue fetch stage: bundle-aligned IM requests, credit-throttled decoupling FIFO,
// redirect with flush, and per-slot valid masks toward the IF/ID queue.
module fetch_stage_n #(
    parameter int FETCH_WIDTH = 2,
    parameter int BUF_DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                PC_init,
    input  logic                       FREEZE,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    fetch_stage_n_if.master            bus,
    output logic [$clog2(BUF_DEPTH):0] buf_count
);
    localparam int BW    = 4 * FETCH_WIDTH;
    localparam int DW    = 32 * FETCH_WIDTH;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] OFF_MASK = 32'(BW - 1);

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~OFF_MASK;
    endfunction

    // Slots before the entry point of an unaligned target are not part of the stream.
    function automatic logic [FETCH_WIDTH-1:0] start_mask(input logic [31:0] a);
        logic [31:0]            slot;
        logic [FETCH_WIDTH-1:0] m;
        slot = (a & OFF_MASK) >> 2;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            m[i] = (32'(i) >= slot);
        end
        return m;
    endfunction

    logic [31:0]            fetch_pc;
    logic                   vld_p1;
    logic [31:0]            tag_pc_p1;
    logic [FETCH_WIDTH-1:0] tag_mask_p1;

    logic [DW-1:0]          instr_buf [BUF_DEPTH];
    logic [31:0]            pc_buf    [BUF_DEPTH];
    logic [FETCH_WIDTH-1:0] mask_buf  [BUF_DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    logic [31:0]            sel_pc_p0;
    logic [31:0]            req_addr_p0;
    logic [FETCH_WIDTH-1:0] req_mask_p0;
    logic                   can_req;
    logic                   req_p0;
    logic                   wr_en;
    logic                   push;
    logic                   not_empty;

    // Stage p0: request selection, credit check and push decision
    always_comb begin
        sel_pc_p0   = redirect_valid ? redirect_pc : fetch_pc;
        req_addr_p0 = align_pc(sel_pc_p0);
        req_mask_p0 = start_mask(sel_pc_p0);
        // Credit counts the response already in flight so a full buffer is never overrun.
        can_req     = (int'(count) + int'(vld_p1)) < BUF_DEPTH;
        req_p0      = can_req && !FREEZE && RESET;
        not_empty   = (count != '0);
        wr_en       = vld_p1 && !redirect_valid;
        push        = not_empty && !bus.tQ_IFID_full && !redirect_valid;
    end

    assign bus.Instr_address_2IM = req_addr_p0;
    assign bus.im_req            = req_p0;
    assign bus.tQ_IFID_pushReq   = push;
    assign bus.out_instr         = not_empty ? instr_buf[head] : '0;
    assign bus.out_pc            = not_empty ? pc_buf[head]    : '0;
    assign bus.out_mask          = not_empty ? mask_buf[head]  : '0;
    assign buf_count             = count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc <= PC_init;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= req_p0;
            if (req_p0) begin
                fetch_pc <= req_addr_p0 + 32'(BW);
            end else if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end
        end
    end

    // Stage p1: request tag travels with the one-cycle IM access
    always_ff @(posedge CLK) begin
        if (req_p0) begin
            tag_pc_p1   <= req_addr_p0;
            tag_mask_p1 <= req_mask_p0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (push) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(push);
        end
    end

    // Stage p2: returned bundle lands in the decoupling buffer
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            instr_buf[tail] <= bus.im_rdata;
            pc_buf[tail]    <= tag_pc_p1;
            mask_buf[tail]  <= tag_mask_p1;
        end
    end
endmodule

// File: doc/fetch_stage_n.md
# fetch_stage_n

Parametrised multi-issue instruction fetch stage: holds the architectural fetch PC, issues bundle-aligned requests to the instruction memory, and buffers returned bundles of FETCH_WIDTH instructions in a small FIFO before pushing them into the IF/ID queue. It is the next-generation front end. It replaces the fixed two-slot fetch path with a configurable width, a decoupling buffer with credit-based request throttling, branch redirect with flush, and per-slot valid masks in place of null-instruction substitution. It sits between the instruction memory and Q_IFID.

## Interface
- FETCH_WIDTH, 2, instructions per bundle; power of 2, range 1..8
- BUF_DEPTH, 4, fetch-buffer entries (bundles); power of 2, range 2..16
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- PC_init  in  32  PC loaded on reset
- FREEZE  in  1  suppress new IM requests; PC held
- redirect_valid  in  1  taken branch/exception redirect this cycle
- redirect_pc  in  32  redirect target, word aligned
- Instr_address_2IM  out  32  IM request address, bundle aligned
- im_req  out  1  IM request strobe
- im_rdata  in  32*FETCH_WIDTH  IM bundle; slot i = bits [32i+31:32i]; valid exactly one cycle after an accepted im_req
- tQ_IFID_full  in  1  downstream queue full
- tQ_IFID_pushReq  out  1  push head bundle into Q_IFID this cycle
- out_instr  out  32*FETCH_WIDTH  head bundle instructions
- out_pc  out  32  head bundle aligned base PC
- out_mask  out  FETCH_WIDTH  per-slot valid; bit i = slot i
- buf_count  out  $clog2(BUF_DEPTH)+1  buffered bundle count

## Operation
- BW = 4*FETCH_WIDTH bytes. align(x) = x & ~(BW-1). All PC arithmetic is modulo 2^32; wrap from 0xFFFFFFF8 to 0x0 is legal.
- Request address: Instr_address_2IM = align(redirect_valid ? redirect_pc : PC). This is combinational, so a redirect is requested in the same cycle.
- Credit: can_req = (buf_count + inflight) < BUF_DEPTH. inflight is a 1-bit register.
- im_req = can_req && !FREEZE.
- Start mask: first slot = (redirect_valid ? redirect_pc : PC)[log2(BW)-1:2]. Slots below it are masked 0, the rest are 1.
- On im_req: inflight <= 1, tag_pc <= request address, tag_mask <= start mask, and PC <= align(addr) + BW.
- Without im_req and with redirect_valid: PC <= redirect_pc (unaligned offset kept for the mask), and no request is issued.
- Response: when inflight is 1 and the response is not squashed, write {tag_pc, im_rdata, tag_mask} at the tail.
- Redirect flush: on redirect_valid, clear the buffer (count 0, pointers 0) and squash any inflight response arriving that cycle. The new request issued in the same cycle is not squashed.
- Push: tQ_IFID_pushReq = (buf_count != 0) && !tQ_IFID_full && !redirect_valid. Head advances on push. out_* always show the head entry and are zero when empty.
- A write and a push in the same cycle are allowed; count is unchanged. Credit guarantees no write to a full buffer. Write to a full buffer is an assertion failure in the bench.
- Priority: RESET > redirect_valid > FREEZE > normal.

## Timing
- Reset (async assert): PC=PC_init; inflight=0; buffer empty; buf_count=0.
  - Outputs: tQ_IFID_pushReq=0, im_req=0, out_instr=0, out_pc=0, out_mask=0, Instr_address_2IM=align(PC_init).
- First cycle after deassert: im_req=1 at align(PC_init) when FREEZE=0.
- Latency: request at cycle t, buffer write at edge t+1, earliest push at cycle t+2.
- Steady state (no stalls): one request per cycle and one push per cycle.
- FREEZE: stops new requests from that cycle. An inflight response still completes, and pushes continue.
- tQ_IFID_full: blocks pushes. Requests continue until buf_count + inflight = BUF_DEPTH.
- Redirect with FREEZE: PC <= redirect_pc. First request goes out the first cycle FREEZE=0.
- Redirect with tQ_IFID_full: flush still happens; no push.
- Reset asserted mid-transfer: pending response is discarded. No push in the cycle reset deasserts.

## Test plan
- FETCH_WIDTH=2, BUF_DEPTH=4, PC_init=0x100, no stalls.
  - Required: addresses 0x100, 0x108, 0x110 on consecutive cycles.
  - Required: first push at cycle 2 with out_pc=0x100, out_mask=2'b11, out_instr={IM[0x104], IM[0x100]}.
- Redirect to 0x204 while one response is inflight and 2 bundles are buffered.
  - Required: address 0x200 that cycle; buffer emptied; stale response dropped.
  - Required: next push has out_pc=0x200, out_mask=2'b10, followed by 0x208 with mask 2'b11.
- tQ_IFID_full held 10 cycles from reset.
  - Required: exactly 4 bundles buffered, then im_req=0 and buf_count=4.
  - Required: on release, 0x100..0x118 pushed in order with no loss, and requests resume.
- FREEZE for 3 cycles, asserted the cycle after a request.
  - Required: im_req=0 and PC held for those cycles; the inflight bundle is still written and pushed.
  - Required: fetch resumes at the next sequential address.
- RESET pulsed low mid-stream with a full buffer.
  - Required: all outputs zero immediately, buf_count=0.
  - Required: after deassert, first request at align(PC_init).
- Same cycle: redirect_valid=1 to 0xFFFFFFF8, FREEZE=1, tQ_IFID_full=1.
  - Required: flush and no push that cycle; after FREEZE drops, request 0xFFFFFFF8, then wrap to 0x00000000.
